// File: rtl/mem_request_queue_if.sv
// Request/head bus between execute, the request queue and the data-memory unit.
// The master side is execute plus memory unit (drives requests, m_stall and report);
// the slave side is the queue itself.
interface mem_request_queue_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 20,
  parameter int unsigned DEPTH_BITS   = 2
);
  // Execute -> queue
  logic                    enq_load;
  logic                    enq_store;
  logic [ADDRESS_BITS-1:0] enq_address;
  logic [DATA_WIDTH-1:0]   enq_data;
  logic                    report;
  // Queue status
  logic                    full;
  logic                    empty;
  logic [DEPTH_BITS:0]     count;
  logic                    req_error;
  // Queue head -> memory unit
  logic                    load;
  logic                    store;
  logic [ADDRESS_BITS-1:0] address;
  logic [DATA_WIDTH-1:0]   store_data;
  // Memory unit -> queue
  logic                    m_stall;

  modport master (
    output enq_load, enq_store, enq_address, enq_data, report, m_stall,
    input  full, empty, count, req_error, load, store, address, store_data
  );

  modport slave (
    input  enq_load, enq_store, enq_address, enq_data, report, m_stall,
    output full, empty, count, req_error, load, store, address, store_data
  );
endinterface

// File: rtl/mem_request_queue.sv
// In-order load/store request FIFO in front of the data-memory unit.
// Optional build macro MEMQ_STATS_EN adds saturating occupancy/stall counters that are
// appended to the report line; the port list is the same in both builds.
module mem_request_queue #(
  parameter int          CORE         = 0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 20,
  parameter int unsigned DEPTH_BITS   = 2
) (
  input logic                clock,
  input logic                reset,
  mem_request_queue_if.slave bus
);

  localparam int unsigned            Depth     = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]    CountFull = Depth[DEPTH_BITS:0];
  localparam logic [DEPTH_BITS-1:0]  PtrOne    = DEPTH_BITS'(1);
  localparam logic [DEPTH_BITS:0]    CountOne  = (DEPTH_BITS + 1)'(1);

  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  req_error_q, req_error_d;

  logic                    ent_store_q [Depth];
  logic [ADDRESS_BITS-1:0] ent_addr_q  [Depth];
  logic [DATA_WIDTH-1:0]   ent_data_q  [Depth];

  logic full, empty;
  logic enq_req, enq_illegal, enq_ok, deq_ok;

  // Flags come only from registered occupancy, never from this cycle's inputs
  always_comb begin
    full        = (count_q == CountFull);
    empty       = (count_q == '0);
    enq_req     = bus.enq_load ^ bus.enq_store;
    enq_illegal = bus.enq_load & bus.enq_store;
    enq_ok      = enq_req & ~full;
    deq_ok      = ~empty & ~bus.m_stall;
  end

  // Next-state for pointers, occupancy and the sticky error flag
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    req_error_d = req_error_q | enq_illegal;
    if (enq_ok) wr_ptr_d = wr_ptr_q + PtrOne;
    if (deq_ok) rd_ptr_d = rd_ptr_q + PtrOne;
    unique case ({enq_ok, deq_ok})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      req_error_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      req_error_q <= req_error_d;
    end
  end

  // Entry storage; contents are don't-care after reset so no reset term
  always_ff @(posedge clock) begin
    if (enq_ok) begin
      ent_store_q[wr_ptr_q] <= bus.enq_store;
      ent_addr_q[wr_ptr_q]  <= bus.enq_address;
      ent_data_q[wr_ptr_q]  <= bus.enq_data;
    end
  end

  // Head presentation and status outputs; all-zero head when nothing is pending
  always_comb begin
    bus.full       = full;
    bus.empty      = empty;
    bus.count      = count_q;
    bus.req_error  = req_error_q;
    bus.load       = 1'b0;
    bus.store      = 1'b0;
    bus.address    = '0;
    bus.store_data = '0;
    if (!empty) begin
      bus.load       = ~ent_store_q[rd_ptr_q];
      bus.store      = ent_store_q[rd_ptr_q];
      bus.address    = ent_addr_q[rd_ptr_q];
      bus.store_data = ent_data_q[rd_ptr_q];
    end
  end

`ifdef MEMQ_STATS_EN
  logic [31:0] full_reject_cycles_q;
  logic [31:0] stall_cycles_q;
  logic [31:0] max_count_q;

  // Saturating statistics counters
  always_ff @(posedge clock) begin
    if (!reset) begin
      full_reject_cycles_q <= '0;
      stall_cycles_q       <= '0;
      max_count_q          <= '0;
    end else begin
      if (enq_req && full && !(&full_reject_cycles_q)) begin
        full_reject_cycles_q <= full_reject_cycles_q + 32'd1;
      end
      if (!empty && bus.m_stall && !(&stall_cycles_q)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (32'(count_q) > max_count_q) begin
        max_count_q <= 32'(count_q);
      end
    end
  end
`endif

`ifndef SYNTHESIS
  logic [31:0] cycle_q;

  // Simulation-only cycle counter and state report
  always_ff @(posedge clock) begin
    if (!reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
    if (bus.report) begin
`ifdef MEMQ_STATS_EN
      $display("memq core %0d cycle %0d count %0d full %0b empty %0b load %0b store %0b addr %h data %h full_rej %0d stall %0d max %0d",
               CORE, cycle_q, count_q, full, empty, bus.load, bus.store, bus.address,
               bus.store_data, full_reject_cycles_q, stall_cycles_q, max_count_q);
`else
      $display("memq core %0d cycle %0d count %0d full %0b empty %0b load %0b store %0b addr %h data %h",
               CORE, cycle_q, count_q, full, empty, bus.load, bus.store, bus.address,
               bus.store_data);
`endif
    end
  end
`endif

endmodule

// File: tb/tb_mem_request_queue.sv
// Directed bench for mem_request_queue: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mem_request_queue;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 20;
  localparam int unsigned DB    = 2;
  localparam int unsigned Depth = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_request_queue_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .DEPTH_BITS(DB)) bus ();

  mem_request_queue #(
    .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .DEPTH_BITS(DB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit            is_store;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t mq[$];
  bit     model_err   = 1'b0;
  bit     model_valid = 1'b0;
  int     vectors     = 0;
  int     miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain FIFO of requests with the queue's accept/retire rules
  always @(posedge clock) begin
    if (!reset) begin
      mq.delete();
      model_err   <= 1'b0;
      model_valid <= 1'b1;
    end else begin
      if (bus.enq_load && bus.enq_store) model_err <= 1'b1;
      if (mq.size() != 0 && !bus.m_stall) begin
        if ((bus.enq_load ^ bus.enq_store) && mq.size() < Depth)
          mq.push_back('{bus.enq_store, bus.enq_address, bus.enq_data});
        void'(mq.pop_front());
      end else if ((bus.enq_load ^ bus.enq_store) && mq.size() < Depth) begin
        mq.push_back('{bus.enq_store, bus.enq_address, bus.enq_data});
      end
    end
  end

  // Every-cycle comparison against the model, on the falling edge
  always @(negedge clock) begin
    if (model_valid) begin
      check("m_empty", bus.empty, mq.size() == 0);
      check("m_full", bus.full, mq.size() == Depth);
      check("m_count", bus.count, mq.size());
      check("m_req_error", bus.req_error, model_err);
      if (mq.size() == 0) begin
        check("m_load", bus.load, 0);
        check("m_store", bus.store, 0);
        check("m_address", bus.address, 0);
        check("m_store_data", bus.store_data, 0);
      end else begin
        check("m_load", bus.load, !mq[0].is_store);
        check("m_store", bus.store, mq[0].is_store);
        check("m_address", bus.address, mq[0].addr);
        check("m_store_data", bus.store_data, mq[0].data);
      end
    end
  end

  task automatic drive(input logic l, input logic s, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    bus.enq_load    = l;
    bus.enq_store   = s;
    bus.enq_address = a;
    bus.enq_data    = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    bus.m_stall = 1'b0;
    bus.report  = 1'b0;
    idle();

    // Reset then idle
    tick();
    tick();
    reset = 1'b1;
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_count", bus.count, 0);
    check("rst_load", bus.load, 0);
    check("rst_store", bus.store, 0);
    check("rst_address", bus.address, 0);
    check("rst_req_error", bus.req_error, 0);
    tick();

    // Single load, no stall
    drive(1'b1, 1'b0, 20'h00040, 32'h0);
    tick();
    idle();
    check("single_load", bus.load, 1);
    check("single_address", bus.address, 20'h00040);
    check("single_count", bus.count, 1);
    tick();
    check("single_drained", bus.empty, 1);

    // Fill under stall, reject the fifth, drain in order
    bus.m_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, AW'(16 * i), DW'(i));
      tick();
    end
    check("fill_full", bus.full, 1);
    check("fill_count", bus.count, 4);
    drive(1'b0, 1'b1, 20'h00050, 32'd5);
    tick();
    check("reject_count", bus.count, 4);
    check("reject_full", bus.full, 1);
    idle();
    bus.m_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("drain_address", bus.address, 16 * i);
      check("drain_store", bus.store, 1);
      check("drain_data", bus.store_data, i);
      tick();
    end
    check("drain_empty", bus.empty, 1);

    // Full: enqueue rejected even with a dequeue in the same cycle
    bus.m_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, AW'(20'h100 + i), DW'(32'hA0 + i));
      tick();
    end
    bus.m_stall = 1'b0;
    drive(1'b0, 1'b1, 20'h00999, 32'h999);
    tick();
    idle();
    check("fulldeq_count", bus.count, 3);
    check("fulldeq_full", bus.full, 0);
    check("fulldeq_head", bus.address, 20'h101);
    tick();
    tick();
    tick();
    check("fulldeq_empty", bus.empty, 1);

    // Simultaneous enqueue/dequeue at count 2, across pointer wrap
    bus.m_stall = 1'b1;
    drive(1'b1, 1'b0, 20'h000A0, 32'h1);
    tick();
    drive(1'b1, 1'b0, 20'h000A1, 32'h2);
    tick();
    check("sim_count_pre", bus.count, 2);
    bus.m_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, AW'(20'hB0 + i), DW'(i));
      tick();
      check("sim_count", bus.count, 2);
      check("sim_head", bus.address, (i == 0) ? 20'hA1 : AW'(20'hB0 + i - 1));
    end
    idle();
    tick();
    tick();
    check("sim_empty", bus.empty, 1);

    // Illegal request is dropped and latches the error flag
    drive(1'b1, 1'b1, 20'h00077, 32'h77);
    tick();
    check("ill_req_error", bus.req_error, 1);
    check("ill_count", bus.count, 0);
    check("ill_empty", bus.empty, 1);
    drive(1'b1, 1'b0, 20'h00055, 32'h0);
    tick();
    idle();
    check("ill_hold1", bus.req_error, 1);
    check("ill_legal_count", bus.count, 1);
    tick();
    check("ill_hold2", bus.req_error, 1);

    // Reset mid-operation
    bus.m_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, AW'(20'h300 + i), DW'(32'h30 + i));
      tick();
    end
    idle();
    check("mid_count", bus.count, 3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_empty", bus.empty, 1);
    check("mid_store", bus.store, 0);
    check("mid_req_error", bus.req_error, 0);
    check("mid_count_zero", bus.count, 0);
    drive(1'b1, 1'b0, 20'h00123, 32'h0);
    tick();
    idle();
    check("post_load", bus.load, 1);
    check("post_address", bus.address, 20'h00123);
    check("post_count", bus.count, 1);
    bus.report = 1'b1;
    tick();
    bus.report  = 1'b0;
    bus.m_stall = 1'b0;
    tick();
    check("post_empty", bus.empty, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_request_queue.md
Name: mem_request_queue

Overview:
- In-order request FIFO directly upstream of the data-memory unit.
- Accepts load/store requests from the execute stage and presents the oldest one on the memory unit's load/store/address/store_data inputs.
- Retires the oldest request only when the memory unit's m_stall is low.
- Decouples execute from multi-cycle cache misses: execute stalls only when the queue is full.

Parameters:
- CORE, 0, core index used in report output.
- DATA_WIDTH, 32, store data width.
- ADDRESS_BITS, 20, request address width.
- DEPTH_BITS, 2, log2 of queue depth (depth = 2^DEPTH_BITS, minimum 1).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clock edge).
- enq_load  input  1  execute requests a load.
- enq_store  input  1  execute requests a store.
- enq_address  input  ADDRESS_BITS  request address.
- enq_data  input  DATA_WIDTH  store data; ignored for loads.
- full  output  1  queue cannot accept; execute must stall.
- empty  output  1  no pending request.
- count  output  DEPTH_BITS+1  current occupancy.
- load  output  1  head entry is a load; to memory unit.
- store  output  1  head entry is a store; to memory unit.
- address  output  ADDRESS_BITS  head address.
- store_data  output  DATA_WIDTH  head store data.
- m_stall  input  1  from memory unit; high = head not yet completed.
- req_error  output  1  sticky: enq_load and enq_store were asserted together.
- report  input  1  print queue state this cycle.

Behaviour:
- Storage: circular buffer of 2^DEPTH_BITS entries {is_store, address, data}. rd_ptr and wr_ptr are DEPTH_BITS wide and wrap modulo depth. count is maintained as a register.
- Reset (reset==0 at clock edge):
  - rd_ptr=wr_ptr=0, count=0, req_error=0.
  - Entry contents are don't-care.
  - Takes priority over every other event. Any in-flight head request is discarded and outputs show empty on the next cycle.
- Flags: full = (count == 2^DEPTH_BITS), empty = (count == 0). Both derive from registered count; no combinational path from enq_* or m_stall.
- Enqueue: enq_ok = (enq_load ^ enq_store) & !full.
  - On the edge: write entry at wr_ptr, wr_ptr+1.
  - Request offered while full is dropped. Execute must hold it, using full as stall.
- Illegal request: enq_load & enq_store in the same cycle enqueues nothing and sets req_error=1. req_error clears only on reset.
- Head presentation (combinational from registers):
  - If !empty: load = !head.is_store, store = head.is_store, address = head.address, store_data = head.data.
  - If empty: load=store=0, address=0, store_data=0.
- Dequeue: deq_ok = !empty & !m_stall. On the edge: rd_ptr+1.
  - The head is held stable on the outputs for every cycle m_stall stays high.
- Simultaneous events:
  - enq_ok & deq_ok: count unchanged, both pointers advance.
  - When full, enqueue is rejected even if a dequeue occurs the same cycle; full deasserts the following cycle.
  - When empty, no bypass: an enqueued entry first appears on the outputs one cycle later. Minimum latency is 1 cycle.
- Ordering: strict FIFO; loads never pass stores.
- count arithmetic: count_next = count + enq_ok - deq_ok, width DEPTH_BITS+1, never exceeds depth.
- Report: on each edge where report==1, $display core, cycle, count, full/empty, and head fields.

Optional Feature:
- Macro MEMQ_STATS_EN.
- Defined: adds 32-bit counters reset by reset==0:
  - full_reject_cycles: cycles with a valid single request and full==1.
  - stall_cycles: cycles with !empty & m_stall.
  - max_count: peak occupancy.
  - All three are appended to the report output. Counters saturate at all-ones.
- Undefined: no counters, no extra logic. Report prints queue state only. Port list is identical in both builds.

Test Plan:
- Reset, then idle: hold reset=0 two cycles, release → empty=1, full=0, count=0, load=store=0, address=0, req_error=0.
- Single load, m_stall=0: enq_load, enq_address=0x00040 for one cycle → next cycle load=1, address=0x00040, count=1; following cycle empty=1.
- Fill and stall, DEPTH_BITS=2: m_stall=1, four stores to 0x10,0x20,0x30,0x40 with data 1..4 → full=1 after 4th. 5th store to 0x50 is rejected with count=4. Release m_stall → outputs 0x10,0x20,0x30,0x40 in order, one per cycle. 0x50 is never issued unless re-offered.
- Simultaneous enq/deq at count=2, m_stall=0 → count stays 2; order is preserved across wr_ptr/rd_ptr wrap past index 3.
- Illegal request: enq_load=enq_store=1 → count unchanged, req_error=1 and held through later legal traffic until reset.
- Reset mid-operation: count=3, m_stall=1, reset=0 one cycle → next cycle empty=1, store=0, req_error=0. A subsequent load enqueues normally at entry 0.
